// File: rtl/debounce_bank.sv
// Multi-channel input debouncer: sample stage, per-channel settle counter, clean level and edge pulses.
// Define DEBOUNCE_BANK_SYNC_EN to add a two-flop synchronizer per channel for asynchronous board pins.
module debounce_bank #(
   parameter int                  CHANNELS      = 8,
   parameter int                  STABLE_CYCLES = 65536,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic [CHANNELS-1:0] dirty,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_event
);

   localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("debounce_bank: STABLE_CYCLES must be >= 1");
      end
   endgenerate

   logic [CHANNELS-1:0]         w_s;
   logic [CHANNELS-1:0]         r_sync;
   logic [CHANNELS-1:0]         r_clean;
   logic [CHANNELS-1:0]         r_rise;
   logic [CHANNELS-1:0]         r_fall;
   logic                        r_any;
   logic [CHANNELS-1:0][CW-1:0] r_cnt;

   logic [CHANNELS-1:0]         w_clean_nxt;
   logic [CHANNELS-1:0]         w_rise_nxt;
   logic [CHANNELS-1:0]         w_fall_nxt;
   logic [CHANNELS-1:0][CW-1:0] w_cnt_nxt;

`ifdef DEBOUNCE_BANK_SYNC_EN
   logic [CHANNELS-1:0] r_meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= dirty;
         r_sync <= r_meta;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= RESET_VALUE;
      end else begin
         r_sync <= dirty;
      end
   end
`endif

   assign w_s = r_sync;

   // Any cycle where the sample agrees with clean restarts qualification.
   always_comb begin
      w_clean_nxt = r_clean;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = '0;
      w_fall_nxt  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_s[i] == r_clean[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (tick) begin
            if (r_cnt[i] == TERM) begin
               w_clean_nxt[i] = w_s[i];
               w_cnt_nxt[i]   = '0;
               w_rise_nxt[i]  = w_s[i];
               w_fall_nxt[i]  = ~w_s[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clean <= RESET_VALUE;
         r_cnt   <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_any   <= 1'b0;
      end else begin
         r_clean <= w_clean_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_any   <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign clean     = r_clean;
   assign rise      = r_rise;
   assign fall      = r_fall;
   assign any_event = r_any;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: directed stimulus pushes expected events, a monitor checks them.
module tb_debounce_bank;

`ifdef DEBOUNCE_BANK_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 1;
`endif

   logic       clk;
   logic       rst;
   logic       tick;
   logic [3:0] dirty;
   logic [3:0] clean;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       any_event;

   debounce_bank #(
      .CHANNELS      (4),
      .STABLE_CYCLES (4),
      .RESET_VALUE   (4'b0001)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .dirty     (dirty),
      .clean     (clean),
      .rise      (rise),
      .fall      (fall),
      .any_event (any_event)
   );

   typedef struct {
      int         cyc;
      logic [3:0] cl;
      logic [3:0] ri;
      logic [3:0] fa;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mon_en = 0;
   bit   tick_mode = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to the next negedge and set tick for the following posedge.
   task automatic step();
      @(negedge clk);
      tick = tick_mode ? ((cyc + 1) % 3 == 0) : 1'b1;
   endtask

   function automatic int nth_tick_edge(input int start, input int n);
      int e = start;
      int c = 0;
      while (c < n) begin
         e++;
         if (e % 3 == 0) c++;
      end
      return e;
   endfunction

   task automatic expect_ev(input int at, input logic [3:0] cl, input logic [3:0] ri,
                            input logic [3:0] fa);
      exp_t e;
      e.cyc = at;
      e.cl  = cl;
      e.ri  = ri;
      e.fa  = fa;
      q.push_back(e);
   endtask

   task automatic drain();
      int budget = 80;
      while (q.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
         q.delete();
      end
      repeat (3) step();
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && ({rise, fall, any_event} !== 9'b0)) begin
            if (q.size() == 0) begin
               check("unexpected_event", {23'b0, rise, fall, any_event}, 32'h0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("ev_cycle", cyc, e.cyc);
               check("ev_clean", clean, e.cl);
               check("ev_rise", rise, e.ri);
               check("ev_fall", fall, e.fa);
               check("ev_any", any_event, 1'b1);
            end
         end
      end
   end

   initial begin
      int n;
      int t2;
      int g;
      int r;
      rst   = 1'b0;
      tick  = 1'b1;
      dirty = 4'b0000;
      repeat (2) step();

      // Asynchronous reset, asserted away from any clock edge.
      #3;
      dirty = 4'b1111;
      rst   = 1'b1;
      #1;
      check("rst_clean", clean, 4'b0001);
      check("rst_rise", rise, 4'b0000);
      check("rst_fall", fall, 4'b0000);
      check("rst_any", any_event, 1'b0);
      step();
      step();
      dirty = 4'b0001;
      step();
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (20) step();
      check("idle_clean", clean, 4'b0001);

      // Stable press on channel 1.
      step();
      dirty = 4'b0011;
      n = cyc;
      expect_ev(n + 4 + SD, 4'b0011, 4'b0010, 4'b0000);
      wait_until(n + 3 + SD);
      check("press_early_clean", clean, 4'b0001);
      drain();

      // Bounce on channel 2, then hold high.
      step(); dirty[2] = 1'b1;
      step(); dirty[2] = 1'b0;
      step(); dirty[2] = 1'b1;
      step(); dirty[2] = 1'b0;
      step(); dirty[2] = 1'b1;
      n = cyc;
      expect_ev(n + 4 + SD, 4'b0111, 4'b0100, 4'b0000);
      drain();

      // Tick every third edge: channel 3 rises after four ticks.
      step();
      tick_mode = 1'b1;
      tick      = ((cyc + 1) % 3 == 0);
      dirty[3]  = 1'b1;
      n = cyc;
      expect_ev(nth_tick_edge(n + SD, 4), 4'b1111, 4'b1000, 4'b0000);
      drain();

      // Falling channel 3 with a one-cycle glitch after two ticks.
      step();
      dirty[3] = 1'b0;
      n  = cyc;
      t2 = nth_tick_edge(n + SD, 2);
      wait_until(t2);
      dirty[3] = 1'b1;
      g = cyc;
      step();
      dirty[3] = 1'b0;
      expect_ev(nth_tick_edge(g + 1 + SD, 4), 4'b0111, 4'b0000, 4'b1000);
      drain();
      tick_mode = 1'b0;
      step();

      // Channel 1 back low, then simultaneous fall[0] and rise[1].
      dirty = 4'b0101;
      n = cyc;
      expect_ev(n + 4 + SD, 4'b0101, 4'b0000, 4'b0010);
      drain();
      step();
      dirty = 4'b0110;
      n = cyc;
      expect_ev(n + 4 + SD, 4'b0110, 4'b0010, 4'b0001);
      drain();
      step();
      dirty = 4'b0001;
      n = cyc;
      expect_ev(n + 4 + SD, 4'b0001, 4'b0001, 4'b0110);
      drain();

      // Reset after two counted edges of a pending change discards the count.
      step();
      dirty = 4'b0011;
      n = cyc;
      wait_until(n + SD + 2);
      #1;
      rst = 1'b1;
      #1;
      check("mrst_clean", clean, 4'b0001);
      check("mrst_rise", rise, 4'b0000);
      check("mrst_fall", fall, 4'b0000);
      check("mrst_any", any_event, 1'b0);
      step();
      step();
      rst = 1'b0;
      r = cyc;
      expect_ev(r + 4 + SD, 4'b0011, 4'b0010, 4'b0000);
      wait_until(r + 3 + SD);
      check("mrst_early_clean", clean, 4'b0001);
      drain();

      check("queue_empty", q.size(), 0);
      check("final_clean", clean, 4'b0011);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
